pipe_add_sub: RTL and testbench

PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

---
 rtl/pipe_add_sub.sv | 130 +++++++++++++
 tb/tb_pipe_add_sub.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_add_sub.sv
// Chunked carry-pipelined adder/subtractor with valid/ready flow control.
// Operands are skewed forward so every bit of one beat leaves together.
module pipe_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = WIDTH / CHUNK;

    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        localparam int REM  = WIDTH - k * CHUNK;
        localparam int DONE = k * CHUNK;

        logic [REM-1:0]        pa;
        logic [REM-1:0]        pb;
        logic                  pc;
        logic                  pv;
        logic [CHUNK:0]        add;
        logic [DONE+CHUNK-1:0] raw;

        if (k == 0) begin : g_in
            assign pa  = a;
            assign pb  = b ^ {WIDTH{m}};
            assign pc  = m;
            assign pv  = in_valid;
            assign raw = add[CHUNK-1:0];
        end else begin : g_in
            assign pa  = g_stage[k-1].g_mid.q_a;
            assign pb  = g_stage[k-1].g_mid.q_b;
            assign pc  = g_stage[k-1].g_mid.q_c;
            assign pv  = g_stage[k-1].g_mid.q_v;
            assign raw = {add[CHUNK-1:0], g_stage[k-1].g_mid.q_s};
        end

        assign add = {1'b0, pa[CHUNK-1:0]}
                   + {1'b0, pb[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, pc};

        if (k < STAGES - 1) begin : g_mid
            // Unconsumed operand chunks shift down so chunk k+1 sits at bit 0.
            logic [REM-CHUNK-1:0]  q_a;
            logic [REM-CHUNK-1:0]  q_b;
            logic [DONE+CHUNK-1:0] q_s;
            logic                  q_c;
            logic                  q_v;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_a <= '0;
                    q_b <= '0;
                    q_s <= '0;
                    q_c <= 1'b0;
                    q_v <= 1'b0;
                end else if (adv) begin
                    q_a <= pa[REM-1:CHUNK];
                    q_b <= pb[REM-1:CHUNK];
                    q_s <= raw;
                    q_c <= add[CHUNK];
                    q_v <= pv;
                end
            end
        end else begin : g_last
            logic             msb_c;
            logic             ov;
            logic [WIDTH-1:0] fin;
            logic [WIDTH-1:0] q_s;
            logic             q_c;
            logic             q_v;
            logic             q_ov;
            logic             q_z;

            assign msb_c = pa[CHUNK-1] ^ pb[CHUNK-1] ^ raw[WIDTH-1];
            assign ov    = msb_c ^ add[CHUNK];

            // Overflow direction follows A's sign: A and B' share it on overflow.
            always_comb begin
                fin = raw;
                if (SAT != 0 && ov) begin
                    if (pa[CHUNK-1])
                        fin = {1'b1, {(WIDTH-1){1'b0}}};
                    else
                        fin = {1'b0, {(WIDTH-1){1'b1}}};
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_s  <= '0;
                    q_c  <= 1'b0;
                    q_v  <= 1'b0;
                    q_ov <= 1'b0;
                    q_z  <= 1'b0;
                end else if (adv) begin
                    q_s  <= fin;
                    q_c  <= add[CHUNK];
                    q_v  <= pv;
                    q_ov <= ov;
                    q_z  <= (fin == '0);
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].g_last.q_v;
    assign sum       = g_stage[STAGES-1].g_last.q_s;
    assign cout      = g_stage[STAGES-1].g_last.q_c;
    assign ovf       = g_stage[STAGES-1].g_last.q_ov;
    assign zero      = g_stage[STAGES-1].g_last.q_z;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: wrapping and saturating instances share stimulus
// and are checked each cycle against an arithmetic reference pipeline.
module tb_pipe_add_sub;
    localparam int W = 16;
    localparam int C = 4;
    localparam int S = W / C;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         m;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         in_ready0, in_ready1;
    logic         out_valid0, out_valid1;
    logic [W-1:0] sum0, sum1;
    logic         cout0, cout1;
    logic         ovf0, ovf1;
    logic         zero0, zero1;

    int errors = 0;
    int checks = 0;
    int delivered = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         m;
    } beat_t;

    beat_t pipe [S];
    bit    pv   [S] = '{default: 1'b0};
    bit    madv;

    always #5 clk = ~clk;

    pipe_add_sub #(.WIDTH(W), .CHUNK(C), .SAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .m(m),
        .out_valid(out_valid0), .out_ready(out_ready),
        .sum(sum0), .cout(cout0), .ovf(ovf0), .zero(zero0)
    );

    pipe_add_sub #(.WIDTH(W), .CHUNK(C), .SAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .m(m),
        .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .zero(zero1)
    );

    // Reference result from signed/unsigned integer arithmetic.
    function automatic void ref_model(
        input  logic [W-1:0] ra, rb,
        input  logic         rm,
        input  bit           sat,
        output logic [W-1:0] rs,
        output logic         rc, rov, rz
    );
        int sa, sb, t;
        sa  = $signed(ra);
        sb  = $signed(rb);
        t   = rm ? sa - sb : sa + sb;
        rov = (t > 32767) || (t < -32768);
        rc  = rm ? (ra >= rb) : ((32'(ra) + 32'(rb)) > 65535);
        rs  = 16'(t);
        if (sat && rov) rs = (t > 0) ? 16'h7FFF : 16'h8000;
        rz  = (rs == 16'h0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit busy();
        bit r = 0;
        for (int i = 0; i < S; i++) r |= pv[i];
        return r;
    endfunction

    // Reference pipeline: a beat advances one slot per cycle unless stalled.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < S; i++) pv[i] = 1'b0;
        end else begin
            madv = !pv[S-1] || out_ready;
            if (madv) begin
                for (int i = S - 1; i > 0; i--) begin
                    pipe[i] = pipe[i-1];
                    pv[i]   = pv[i-1];
                end
                pipe[0] = '{a: a, b: b, m: m};
                pv[0]   = in_valid;
            end
        end
    end

    always @(negedge clk) begin
        logic [W-1:0] es;
        logic         ec, eo, ez;
        chk("in_ready0", in_ready0, !pv[S-1] || out_ready);
        chk("in_ready1", in_ready1, !pv[S-1] || out_ready);
        chk("out_valid0", out_valid0, pv[S-1]);
        chk("out_valid1", out_valid1, pv[S-1]);
        if (rst) begin
            chk("rst_sum", sum0, 0);
            chk("rst_zero", zero0, 0);
            chk("rst_cout", cout0, 0);
            chk("rst_ovf", ovf1, 0);
        end else if (pv[S-1]) begin
            ref_model(pipe[S-1].a, pipe[S-1].b, pipe[S-1].m, 0, es, ec, eo, ez);
            chk("sum0", sum0, es);
            chk("cout0", cout0, ec);
            chk("ovf0", ovf0, eo);
            chk("zero0", zero0, ez);
            ref_model(pipe[S-1].a, pipe[S-1].b, pipe[S-1].m, 1, es, ec, eo, ez);
            chk("sum1", sum1, es);
            chk("cout1", cout1, ec);
            chk("ovf1", ovf1, eo);
            chk("zero1", zero1, ez);
            if (out_ready) delivered++;
        end
    end

    task automatic single(input logic [W-1:0] ta, tb_, input logic tm,
                          input logic [W-1:0] es0, es1);
        int lat;
        @(posedge clk); #2;
        a = ta; b = tb_; m = tm; in_valid = 1'b1;
        @(negedge clk);
        chk("accept", in_ready0, 1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid0 && lat < 20);
        chk("latency", lat, S);
        chk("lit_sum0", sum0, es0);
        chk("lit_sum1", sum1, es1);
    endtask

    task automatic stream(input int n, input int stall_at);
        beat_t bts[$];
        int idx = 0;
        int cyc = 0;
        for (int i = 0; i < n; i++)
            bts.push_back('{a: W'($urandom), b: W'($urandom), m: 1'(i % 2)});
        while (idx < n && cyc < 200) begin
            @(posedge clk); #2;
            out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
            in_valid  = 1'b1;
            a = bts[idx].a; b = bts[idx].b; m = bts[idx].m;
            @(negedge clk);
            if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3)
                chk("stall_in_ready", in_ready0, 0);
            if (in_ready0) idx++;
            cyc++;
        end
        chk("stream_done", idx, n);
        @(posedge clk); #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (busy() && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", busy(), 0);
    endtask

    initial begin
        logic [W-1:0] s;
        logic         c, o, z;
        int           d0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; m = 1'b0;
        #1;
        chk("reset_out_valid", out_valid0, 0);
        chk("reset_in_ready", in_ready0, 1);
        chk("reset_zero", zero0, 0);

        ref_model(16'hFFFF, 16'h0001, 0, 0, s, c, o, z);
        chk("pin_ffff_sum", s, 16'h0000);
        chk("pin_ffff_cout", c, 1);
        chk("pin_ffff_ovf", o, 0);
        chk("pin_ffff_zero", z, 1);
        ref_model(16'h7FFF, 16'h0001, 0, 0, s, c, o, z);
        chk("pin_7fff_sum", s, 16'h8000);
        chk("pin_7fff_ovf", o, 1);
        chk("pin_7fff_cout", c, 0);
        ref_model(16'h7FFF, 16'h0001, 0, 1, s, c, o, z);
        chk("pin_7fff_sat", s, 16'h7FFF);
        chk("pin_7fff_satz", z, 0);
        ref_model(16'h0000, 16'h0001, 1, 0, s, c, o, z);
        chk("pin_sub_sum", s, 16'hFFFF);
        chk("pin_sub_cout", c, 0);
        chk("pin_sub_ovf", o, 0);
        ref_model(16'h0005, 16'h0005, 1, 0, s, c, o, z);
        chk("pin_eq_sum", s, 16'h0000);
        chk("pin_eq_cout", c, 1);
        chk("pin_eq_zero", z, 1);
        ref_model(16'h8000, 16'h0001, 1, 1, s, c, o, z);
        chk("pin_neg_sat", s, 16'h8000);

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        single(16'hFFFF, 16'h0001, 0, 16'h0000, 16'h0000);
        single(16'h7FFF, 16'h0001, 0, 16'h8000, 16'h7FFF);
        single(16'h0000, 16'h0001, 1, 16'hFFFF, 16'hFFFF);
        single(16'h0005, 16'h0005, 1, 16'h0000, 16'h0000);
        single(16'h8000, 16'h0001, 1, 16'h7FFF, 16'h8000);
        drain();

        d0 = delivered;
        stream(8, -1);
        drain();
        chk("stream8_count", delivered - d0, 8);

        d0 = delivered;
        stream(8, 5);
        drain();
        chk("stall_count", delivered - d0, 8);

        d0 = delivered;
        stream(40, 11);
        drain();
        chk("long_count", delivered - d0, 40);

        d0 = delivered;
        stream(3, -1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid0", out_valid0, 0);
        chk("rst_async_valid1", out_valid1, 0);
        chk("rst_async_sum", sum0, 0);
        chk("rst_async_ready", in_ready0, 1);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("flushed", delivered - d0, 0);
        single(16'h1234, 16'h0F0F, 0, 16'h2143, 16'h2143);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
